mul_int8_accum: RTL

Downstream accumulation stage for the 8-bit integer multiplier datapath. Consumes a stream of WIDTH-bit products, sums them into a wider accumulator, and emits one result per group of terms terminated by `last` or by the term-count limit. All data and control paths use valid/ready handshakes. The result is held stable until the consumer accepts it.

---
 rtl/mul_int8_accum.sv | 115 +++++++++++
 1 files changed

// File: rtl/mul_int8_accum.sv
// mul_int8_accum: accumulates a stream of unsigned products into a wider sum.
// One result (SUM, COUNT, OVF) is emitted per group, closed by in_last or by
// reaching MAX_TERMS terms. The result is held until the consumer takes it.
module mul_int8_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_TERMS = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     P,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] SUM,
  output logic [7:0]           COUNT,
  output logic                 OVF
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Count value at which the term being accepted is the last one allowed.
  localparam logic [7:0] LAST_IDX = 8'(MAX_TERMS - 1);

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [7:0]           cnt_q;
  logic                 ovf_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic [7:0]           count_q;
  logic                 ovf_out_q;

  logic [ACC_WIDTH:0]   add_full;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [7:0]           cnt_d;
  logic                 ovf_d;
  logic                 close_d;
  logic                 accept;

  // Running sum with the carry kept one bit above the accumulator width.
  assign add_full = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, P};
  assign acc_d    = add_full[ACC_WIDTH-1:0];
  assign ovf_d    = ovf_q | add_full[ACC_WIDTH];
  assign cnt_d    = cnt_q + 8'd1;
  assign close_d  = in_last || (cnt_q == LAST_IDX);

  // NOTE: in_ready is the only combinational output; it must drop in the very
  // cycle clr is asserted, so it cannot come from a register.
  assign in_ready = (state_q == ST_ACC) && !clr;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign SUM       = sum_q;
  assign COUNT     = count_q;
  assign OVF       = ovf_out_q;

  // Group FSM: accumulate in ACC, hold the registered result in DONE.
  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      count_q     <= '0;
      ovf_out_q   <= 1'b0;
    end else if (clr) begin
      // Abort: drop the partial group and any pending result.
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (close_d) begin
              sum_q       <= acc_d;
              count_q     <= cnt_d;
              ovf_out_q   <= ovf_d;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

endmodule
